// File: rtl/vend_pkg.sv
// Purpose: shared types and defaults for the vending coin/credit blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package vend_pkg;

  // Refund state machine states.
  typedef enum logic {
    IDLE   = 1'b0,
    CHANGE = 1'b1
  } vend_state_t;

  // One credit unit is worth 25 centavos.
  localparam int CREDIT_UNIT_CENTAVOS = 25;

  // Default coin set: index 0 = 1 unit, 1 = 2 units, 2 = 4 units.
  localparam int          DEF_N_COINS    = 3;
  localparam logic [23:0] DEF_COIN_VAL   = {8'd4, 8'd2, 8'd1};
  localparam int          DEF_MAX_CREDIT = 15;

endpackage

// File: rtl/coin_edge_sel.sv
// Purpose: rising-edge detect on coin sensors, pick highest-index edge, flag extra edges.
// Latency: outputs are combinational from coin_in and the registered previous level.
// Backpressure: none; sensors sampled every cycle, surplus edges reported on sel_drop.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   coin_in    : raw sensor levels, one bit per denomination
//   sel_vld    : at least one rising edge this cycle
//   sel_idx    : highest index with a rising edge (valid with sel_vld)
//   sel_drop   : more than one edge this cycle; lower ones are discarded
module coin_edge_sel
  import vend_pkg::*;
#(
  parameter int N     = DEF_N_COINS,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     coin_in,
  output logic             sel_vld,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_drop
);

  logic [N-1:0] coin_prev;
  logic [N-1:0] edges;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_prev <= '0;
    end else begin
      coin_prev <= coin_in;
    end
  end

  assign edges = coin_in & ~coin_prev;

  // Ascending scan: the last hit is the highest index; any hit after the
  // first means a lower-index edge is being thrown away.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (edges[i]) begin
        if (sel_vld) begin
          sel_drop = 1'b1;
        end
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/coin_credit_manager.sv
// Purpose: coin credit accumulator with saturating add, debit handshake and largest-first refund.
// Latency: 1 clk from inputs to every registered output.
// Backpressure: none; coins that cannot be credited are refused via coin_reject, buys via buy_nack.
//
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   coin_in          : coin sensor levels (edge counted once)
//   buy_req, price   : purchase request and price in credit units
//   cancel           : refund all credit
//   credit           : current credit
//   coin_reject      : pulse, an inserted coin was not credited
//   buy_ack/buy_nack : pulse, purchase accepted / refused
//   change_coin      : one-hot pulse to the change hopper
//   change_busy      : refund in progress
//   change_done      : pulse, refund complete
module coin_credit_manager
  import vend_pkg::*;
#(
  parameter int                   N_COINS    = DEF_N_COINS,
  parameter int                   CREDIT_W   = 4,
  parameter logic [N_COINS*8-1:0] COIN_VAL   = DEF_COIN_VAL,
  parameter int                   MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int                   CHANGE_GAP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_COINS-1:0]  coin_in,
  input  logic                buy_req,
  input  logic [CREDIT_W-1:0] price,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                buy_ack,
  output logic                buy_nack,
  output logic [N_COINS-1:0]  change_coin,
  output logic                change_busy,
  output logic                change_done
);

  localparam int IDX_W = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;
  // Wide enough that credit - debit + coin value can never wrap.
  localparam int WW = CREDIT_W + 8;
  localparam logic [WW-1:0]    MAX_W      = WW'(MAX_CREDIT);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHANGE_GAP - 1);

  function automatic logic [7:0] coin_val(input logic [IDX_W-1:0] idx);
    coin_val = COIN_VAL[int'(idx)*8 +: 8];
  endfunction

  vend_state_t         state;
  logic [GAP_W-1:0]    gap_cnt;
  logic                done_pend;

  logic                sel_vld;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_drop;

  logic                buy_ok;
  logic [CREDIT_W-1:0] debit;
  logic [WW-1:0]       sum_w;
  logic                coin_fits;
  logic [IDX_W-1:0]    chg_idx;
  logic [CREDIT_W-1:0] chg_val;

  coin_edge_sel #(
    .N     (N_COINS),
    .IDX_W (IDX_W)
  ) u_edge_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin_in  (coin_in),
    .sel_vld  (sel_vld),
    .sel_idx  (sel_idx),
    .sel_drop (sel_drop)
  );

  assign buy_ok    = buy_req && (credit >= price);
  assign debit     = buy_ok ? price : '0;
  // debit <= credit, so the subtraction cannot underflow.
  assign sum_w     = WW'(credit) - WW'(debit) + WW'(coin_val(sel_idx));
  assign coin_fits = (sum_w <= MAX_W);

  // Largest denomination not exceeding the remaining credit. Index 0 is
  // worth one unit, so a nonzero credit always finds a coin.
  always_comb begin
    chg_idx = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (WW'(coin_val(IDX_W'(i))) <= WW'(credit)) begin
        chg_idx = IDX_W'(i);
      end
    end
  end

  assign chg_val     = CREDIT_W'(coin_val(chg_idx));
  assign change_busy = (state == CHANGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      gap_cnt     <= '0;
      done_pend   <= 1'b0;
      coin_reject <= 1'b0;
      buy_ack     <= 1'b0;
      buy_nack    <= 1'b0;
      change_coin <= '0;
      change_done <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      buy_ack     <= 1'b0;
      buy_nack    <= 1'b0;
      change_coin <= '0;
      // done_pend delays the completion pulse one cycle behind the last coin.
      change_done <= done_pend;
      done_pend   <= 1'b0;

      case (state)
        IDLE: begin
          if (cancel) begin
            buy_nack    <= buy_req;
            coin_reject <= sel_vld;
            if (credit == '0) begin
              change_done <= 1'b1;
            end else begin
              state   <= CHANGE;
              gap_cnt <= '0;
            end
          end else begin
            buy_ack  <= buy_ok;
            buy_nack <= buy_req && !buy_ok;
            if (sel_vld && coin_fits) begin
              credit      <= sum_w[CREDIT_W-1:0];
              coin_reject <= sel_drop;
            end else begin
              credit      <= credit - debit;
              coin_reject <= sel_vld;
            end
          end
        end

        CHANGE: begin
          coin_reject <= sel_vld;
          buy_nack    <= buy_req;
          if (gap_cnt == '0) begin
            change_coin <= N_COINS'(1) << chg_idx;
            credit      <= credit - chg_val;
            gap_cnt     <= GAP_RELOAD;
            if (credit == chg_val) begin
              state     <= IDLE;
              done_pend <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
